// File: rtl/led_event_stretcher.sv
// Stretches single-cycle event strobes into visible LED blinks timed by a slow CE tick.
// Events arriving mid-blink are queued in a saturating counter and replayed after a forced off-gap.
module led_event_stretcher #(
    parameter int       ON_TICKS   = 8,
    parameter int       GAP_TICKS  = 4,
    parameter int       CNTR_WIDTH = 4,
    parameter int       PEND_WIDTH = 3,
    parameter bit       LED_POL    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic                  EVT_IN,
    output logic                  LED_OUT,
    output logic                  BUSY,
    output logic [PEND_WIDTH-1:0] PEND_CNT,
    output logic                  OVF
);

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    localparam logic [CNTR_WIDTH-1:0] ON_LAST  = CNTR_WIDTH'(ON_TICKS - 1);
    localparam logic [CNTR_WIDTH-1:0] GAP_LAST = CNTR_WIDTH'(GAP_TICKS - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    state_t                state;
    logic [CNTR_WIDTH-1:0] tick_cnt;
    logic                  gap_end;
    logic                  restart;

    assign gap_end = (state == GAP) && CE && (tick_cnt == GAP_LAST);
    assign restart = gap_end && ((PEND_CNT != '0) || EVT_IN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            tick_cnt <= '0;
            LED_OUT  <= ~LED_POL;
            BUSY     <= 1'b0;
            PEND_CNT <= '0;
            OVF      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (EVT_IN) begin
                        state    <= ON;
                        LED_OUT  <= LED_POL;
                        BUSY     <= 1'b1;
                        tick_cnt <= '0;
                    end
                end
                ON: begin
                    if (CE) begin
                        if (tick_cnt == ON_LAST) begin
                            state    <= GAP;
                            LED_OUT  <= ~LED_POL;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (CE) begin
                        if (tick_cnt == GAP_LAST) begin
                            tick_cnt <= '0;
                            if (restart) begin
                                state   <= ON;
                                LED_OUT <= LED_POL;
                            end else begin
                                state <= IDLE;
                                BUSY  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    LED_OUT  <= ~LED_POL;
                    BUSY     <= 1'b0;
                end
            endcase

            // A strobe that itself restarts a blink is consumed, not queued.
            if ((state != IDLE) && EVT_IN && !restart) begin
                if (PEND_CNT != PEND_MAX)
                    PEND_CNT <= PEND_CNT + 1'b1;
                else
                    OVF <= 1'b1;
            end else if (restart && !EVT_IN && (PEND_CNT != '0)) begin
                PEND_CNT <= PEND_CNT - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_event_stretcher.sv
// Directed bench: a blink scoreboard checks each LED pulse length, plus state checks per step.
module tb_led_event_stretcher;

    logic       clk = 1'b0;
    logic       rst, ce, evt0, evt1;
    logic       led0, busy0, ovf0, led1, busy1, ovf1;
    logic [2:0] pend0, pend1;

    bit ce_en = 1'b0;
    int phase = 0;
    int n_pass = 0;
    int n_total = 0;
    int blinks = 0;
    int exp_blinks = 0;
    int sb[$];

    led_event_stretcher u0 (
        .CLK(clk), .RST(rst), .CE(ce), .EVT_IN(evt0),
        .LED_OUT(led0), .BUSY(busy0), .PEND_CNT(pend0), .OVF(ovf0)
    );

    led_event_stretcher #(.ON_TICKS(1), .GAP_TICKS(1), .LED_POL(1'b0)) u1 (
        .CLK(clk), .RST(rst), .CE(ce), .EVT_IN(evt1),
        .LED_OUT(led1), .BUSY(busy1), .PEND_CNT(pend1), .OVF(ovf1)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one clock; CE pulses every 4th cycle when enabled.
    task automatic step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
        ce = ce_en && (phase == 3);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 2000 && busy0; k++) step();
        chk(tag, busy0, 0);
    endtask

    // Blink monitor: counts CE pulses while the LED is on / in the gap.
    initial begin
        int  on_ce = 0;
        int  gap_ce = 0;
        bit  prev_on = 0;
        bit  prev_gap = 0;
        bit  cur_on, cur_gap;
        forever begin
            @(negedge clk);
            if (rst) begin
                on_ce = 0; gap_ce = 0; prev_on = 0; prev_gap = 0;
            end else begin
                cur_on  = (led0 === 1'b1);
                cur_gap = (busy0 === 1'b1) && (led0 === 1'b0);
                if (prev_on && !cur_on) begin
                    blinks++;
                    if (sb.size() == 0) chk("sb_unexpected_blink", 1, 0);
                    else chk("on_len", on_ce, sb.pop_front());
                    on_ce = 0;
                    gap_ce = 0;
                end
                if (prev_gap && !cur_gap) begin
                    chk("gap_len", gap_ce, 4);
                    gap_ce = 0;
                end
                if (cur_on && ce) on_ce++;
                if (cur_gap && ce) gap_ce++;
                prev_on = cur_on;
                prev_gap = cur_gap;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; ce = 1'b0; evt0 = 1'b0; evt1 = 1'b0;
        step(); step();
        chk("rst_led", led0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_pend", pend0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_led_pol0", led1, 1);
        chk("rst_busy_pol0", busy1, 0);
        rst = 1'b0;
        ce_en = 1'b1;

        // single strobe
        evt0 = 1'b1; sb.push_back(8); exp_blinks++;
        step(); evt0 = 1'b0;
        chk("t1_led_on", led0, 1);
        chk("t1_busy", busy0, 1);
        chk("t1_pend", pend0, 0);
        wait_idle("t1_idle");
        chk("t1_led_off", led0, 0);
        chk("t1_pend_end", pend0, 0);

        // three back-to-back strobes
        evt0 = 1'b1;
        repeat (3) sb.push_back(8);
        exp_blinks += 3;
        step(); chk("t2_pend0", pend0, 0); chk("t2_led", led0, 1);
        step(); chk("t2_pend1", pend0, 1);
        step(); chk("t2_pend2", pend0, 2);
        evt0 = 1'b0;
        for (int k = 0; k < 500 && pend0 == 2; k++) step();
        chk("t2_dec_to1", pend0, 1);
        chk("t2_restart_led", led0, 1);
        chk("t2_restart_busy", busy0, 1);
        for (int k = 0; k < 500 && pend0 == 1; k++) step();
        chk("t2_dec_to0", pend0, 0);
        chk("t2_restart2_led", led0, 1);
        wait_idle("t2_idle");

        // overflow: one strobe starts a blink, ten more queue against a depth of 7
        evt0 = 1'b1;
        repeat (11) step();
        evt0 = 1'b0;
        repeat (8) sb.push_back(8);
        exp_blinks += 8;
        chk("t3_pend_sat", pend0, 7);
        chk("t3_ovf", ovf0, 1);
        wait_idle("t3_idle");
        chk("t3_ovf_sticky", ovf0, 1);
        chk("t3_pend_end", pend0, 0);

        // event on the final gap CE restarts directly
        evt0 = 1'b1; sb.push_back(8); sb.push_back(8); exp_blinks += 2;
        step(); evt0 = 1'b0;
        for (int k = 0; k < 200 && led0; k++) step();
        n = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            if (ce) n++;
            if (n == 4) evt0 = 1'b1;
            step();
        end
        evt0 = 1'b0;
        chk("t4_led_restart", led0, 1);
        chk("t4_busy_held", busy0, 1);
        chk("t4_pend", pend0, 0);
        wait_idle("t4_idle");

        // reset mid-blink with events queued
        evt0 = 1'b1;
        repeat (4) step();
        evt0 = 1'b0;
        chk("t5_pend3", pend0, 3);
        chk("t5_led_on", led0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_led", led0, 0);
        chk("t5_rst_pend", pend0, 0);
        chk("t5_rst_busy", busy0, 0);
        chk("t5_rst_ovf", ovf0, 0);
        evt0 = 1'b1; sb.push_back(8); exp_blinks++;
        step(); evt0 = 1'b0;
        chk("t5_led_on2", led0, 1);
        wait_idle("t5_idle");

        // active-low LED, 1-tick on and gap
        evt1 = 1'b1;
        step(); evt1 = 1'b0;
        chk("t6_led_low", led1, 0);
        chk("t6_busy", busy1, 1);
        for (int k = 0; k < 20 && !ce; k++) step();
        chk("t6_held_until_ce", led1, 0);
        step();
        chk("t6_gap_led", led1, 1);
        chk("t6_gap_busy", busy1, 1);
        for (int k = 0; k < 20 && !ce; k++) step();
        step();
        chk("t6_idle_busy", busy1, 0);
        chk("t6_idle_led", led1, 1);

        step(); step();
        chk("blink_count", blinks, exp_blinks);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
